// File: rtl/convolutional_encoder_pkg.sv
// Shared constants for the K=7 convolutional encoder: generators, rate codes, FSM encoding.
// The optional puncturing logic is enabled by CONV_PUNCTURING_EN.
package convolutional_encoder_pkg;

    localparam logic [6:0] G0_DEFAULT = 7'o133;
    localparam logic [6:0] G1_DEFAULT = 7'o171;

    localparam logic [1:0] RATE_1_2 = 2'd0;
    localparam logic [1:0] RATE_2_3 = 2'd1;
    localparam logic [1:0] RATE_3_4 = 2'd2;

    localparam int unsigned PUNCT_PERIOD_MAX = 3;
    localparam int unsigned PH_W             = $clog2(PUNCT_PERIOD_MAX);

    localparam logic [1:0] ST_READY  = 2'd0;
    localparam logic [1:0] ST_SEND_A = 2'd1;
    localparam logic [1:0] ST_SEND_B = 2'd2;

    // Generator MSB taps the current input; lower bits walk back through s[0]..s[5].
    function automatic logic conv_tap(input logic [6:0] g, input logic in, input logic [5:0] s);
        logic [6:0] w;
        w = {in, s[0], s[1], s[2], s[3], s[4], s[5]};
        return ^(g & w);
    endfunction

endpackage

// File: rtl/convolutional_encoder_puncture_map.sv
// Puncture pattern lookup: (rate, phase) -> which coded bits to keep and the next phase.
// Only built when CONV_PUNCTURING_EN is defined.
`ifdef CONV_PUNCTURING_EN
module conv_puncture_map
    import convolutional_encoder_pkg::*;
(
    input  logic [1:0]      i_rate,
    input  logic [PH_W-1:0] i_ph,
    output logic            o_keep_a,
    output logic            o_keep_b,
    output logic [PH_W-1:0] o_ph_next
);

    always_comb begin
        o_keep_a  = 1'b1;
        o_keep_b  = 1'b1;
        o_ph_next = '0;
        case (i_rate)
            RATE_2_3: begin
                if (i_ph == '0) begin
                    o_ph_next = PH_W'(1);
                end else begin
                    o_keep_b = 1'b0;
                end
            end
            RATE_3_4: begin
                case (i_ph)
                    PH_W'(0): o_ph_next = PH_W'(1);
                    PH_W'(1): begin
                        o_keep_b  = 1'b0;
                        o_ph_next = PH_W'(2);
                    end
                    default: o_keep_a = 1'b0;
                endcase
            end
            // Rate 1/2 and the reserved code keep both bits and hold phase 0.
            default: ;
        endcase
    end

endmodule
`endif

// File: rtl/convolutional_encoder.sv
// Rate-1/2 K=7 convolutional encoder with serial coded output.
// Define CONV_PUNCTURING_EN to add 802.11a puncturing to rates 2/3 and 3/4.
module convolutional_encoder
    import convolutional_encoder_pkg::*;
#(
    parameter logic [6:0] G0 = G0_DEFAULT,
    parameter logic [6:0] G1 = G1_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [1:0] i_rate,
    input  logic       i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_data,
    output logic       o_valid
);

    logic [1:0] r_state;
    logic [5:0] r_s;
    logic       r_a;
    logic       r_b;
    logic       r_keep_b;

    logic w_keep_a;
    logic w_keep_b;
    logic w_accept;
    logic w_last;
    logic w_a;
    logic w_b;

`ifdef CONV_PUNCTURING_EN
    logic [1:0]      r_rate;
    logic [PH_W-1:0] r_ph;
    logic [PH_W-1:0] w_ph_next;

    conv_puncture_map u_puncture_map (
        .i_rate    (r_rate),
        .i_ph      (r_ph),
        .o_keep_a  (w_keep_a),
        .o_keep_b  (w_keep_b),
        .o_ph_next (w_ph_next)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rate <= RATE_1_2;
            r_ph   <= '0;
        end else if (i_start) begin
            r_rate <= i_rate;
            r_ph   <= '0;
        end else if (w_accept) begin
            r_ph <= w_ph_next;
        end
    end
`else
    logic w_unused_rate;

    assign w_keep_a      = 1'b1;
    assign w_keep_b      = 1'b1;
    assign w_unused_rate = ^i_rate;
`endif

    assign w_a = conv_tap(G0, i_data, r_s);
    assign w_b = conv_tap(G1, i_data, r_s);

    // A new bit may enter while the final kept bit of the previous one is on the wire.
    assign w_last   = (r_state == ST_SEND_B) || ((r_state == ST_SEND_A) && !r_keep_b);
    assign o_ready  = ((r_state == ST_READY) || w_last) && !i_start && !i_reset;
    assign w_accept = i_valid && o_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= ST_READY;
            r_s      <= '0;
            r_a      <= 1'b0;
            r_b      <= 1'b0;
            r_keep_b <= 1'b0;
        end else if (i_start) begin
            r_state <= ST_READY;
            r_s     <= '0;
        end else if (w_accept) begin
            r_s      <= {r_s[4:0], i_data};
            r_a      <= w_a;
            r_b      <= w_b;
            r_keep_b <= w_keep_b;
            r_state  <= w_keep_a ? ST_SEND_A : ST_SEND_B;
        end else begin
            case (r_state)
                ST_SEND_A: r_state <= r_keep_b ? ST_SEND_B : ST_READY;
                default:   r_state <= ST_READY;
            endcase
        end
    end

    always_comb begin
        o_valid = 1'b0;
        o_data  = 1'b0;
        case (r_state)
            ST_SEND_A: begin
                o_valid = 1'b1;
                o_data  = r_a;
            end
            ST_SEND_B: begin
                o_valid = 1'b1;
                o_data  = r_b;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_convolutional_encoder.sv
// Directed self-checking bench for convolutional_encoder; puncturing cases follow
// CONV_PUNCTURING_EN, otherwise the rate-ignored behaviour is checked.
module tb_convolutional_encoder;
    import convolutional_encoder_pkg::*;

    logic       clk     = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_start = 1'b0;
    logic [1:0] i_rate  = 2'd0;
    logic       i_data  = 1'b0;
    logic       i_valid = 1'b0;
    logic       o_ready;
    logic       o_data;
    logic       o_valid;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    logic q[$];
    int   acc[$];

    convolutional_encoder dut (
        .i_clk   (clk),
        .i_reset (i_reset),
        .i_start (i_start),
        .i_rate  (i_rate),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_valid (o_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_valid === 1'b1) q.push_back(o_data);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] q_bits();
        logic [31:0] v;
        v = '0;
        foreach (q[i]) v = {v[30:0], q[i]};
        return v;
    endfunction

    task automatic clear_q();
        @(posedge clk);
        q.delete();
        acc.delete();
        @(negedge clk);
    endtask

    task automatic drain();
        repeat (4) @(negedge clk);
    endtask

    task automatic do_start(input logic [1:0] rate);
        i_start = 1'b1;
        i_rate  = rate;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    // bits[n-1] is sent first.
    task automatic send_bits(input logic [15:0] bits, input int n);
        int cnt;
        for (int i = 0; i < n; i++) begin
            cnt = 0;
            while (o_ready !== 1'b1 && cnt < 20) begin
                @(negedge clk);
                cnt++;
            end
            if (cnt >= 20) check_eq("ready_timeout", o_ready, 1);
            i_valid = 1'b1;
            i_data  = bits[n-1-i];
            acc.push_back(cyc);
            @(negedge clk);
            i_valid = 1'b0;
            i_data  = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_valid", o_valid, 0);
        check_eq("rst_data", o_data, 0);
        check_eq("rst_ready", o_ready, 0);
        i_reset = 1'b0;
        #1;
        check_eq("ready_after_rst", o_ready, 1);
        @(negedge clk);

        // Impulse at rate 1/2
        do_start(RATE_1_2);
        clear_q();
        send_bits(16'b1000000, 7);
        drain();
        check_eq("r12_bits", q_bits(), 32'b11_01_11_11_00_10_11);
        check_eq("r12_count", q.size(), 14);
        for (int i = 1; i < 7; i++) check_eq("r12_spacing", acc[i] - acc[i-1], 2);

        // Rate 2/3 (ignored without puncturing)
        do_start(RATE_2_3);
        clear_q();
        send_bits(16'b10, 2);
        drain();
`ifdef CONV_PUNCTURING_EN
        check_eq("r23_first_bits", q_bits(), 32'b110);
        check_eq("r23_first_count", q.size(), 3);
`else
        check_eq("r23_ign_first_bits", q_bits(), 32'b1101);
        check_eq("r23_ign_first_count", q.size(), 4);
`endif
        clear_q();
        send_bits(16'b00, 2);
        drain();
`ifdef CONV_PUNCTURING_EN
        check_eq("r23_second_bits", q_bits(), 32'b111);
        check_eq("r23_second_count", q.size(), 3);
`else
        check_eq("r23_ign_second_bits", q_bits(), 32'b1111);
        check_eq("r23_ign_second_count", q.size(), 4);
`endif

        // Rate 3/4, six bits so the phase wraps once
        do_start(RATE_3_4);
        clear_q();
        send_bits(16'b100000, 6);
        drain();
`ifdef CONV_PUNCTURING_EN
        check_eq("r34_bits", q_bits(), 32'b1101_1100);
        check_eq("r34_count", q.size(), 8);
        check_eq("r34_three_in_four", acc[3] - acc[0], 4);
`else
        check_eq("r34_ign_bits", q_bits(), 32'b11_01_11_11_00_10);
        check_eq("r34_ign_count", q.size(), 12);
`endif

        // Start during SEND_A drops the emission and clears the shift register
        do_start(RATE_1_2);
        clear_q();
        send_bits(16'b1, 1);
        check_eq("mid_valid_before", o_valid, 1);
        i_start = 1'b1;
        i_rate  = RATE_1_2;
        @(negedge clk);
        i_start = 1'b0;
        check_eq("mid_valid_dropped", o_valid, 0);
        clear_q();
        send_bits(16'b1, 1);
        drain();
        check_eq("mid_restart_bits", q_bits(), 32'b11);
        check_eq("mid_restart_count", q.size(), 2);

        // Start with InputValid: Start wins, then Rate change without Start is ignored
        i_start = 1'b1;
        i_rate  = RATE_2_3;
        i_valid = 1'b1;
        i_data  = 1'b1;
        #1;
        check_eq("sv_ready_low", o_ready, 0);
        @(negedge clk);
        i_start = 1'b0;
        i_valid = 1'b0;
        i_data  = 1'b0;
        check_eq("sv_not_accepted", o_valid, 0);
        i_rate = RATE_3_4;
        clear_q();
        send_bits(16'b100, 3);
        drain();
`ifdef CONV_PUNCTURING_EN
        check_eq("rate_hold_bits", q_bits(), 32'b11011);
        check_eq("rate_hold_count", q.size(), 5);
`else
        check_eq("rate_hold_bits", q_bits(), 32'b110111);
        check_eq("rate_hold_count", q.size(), 6);
`endif

        // Reset mid-frame
        do_start(RATE_1_2);
        clear_q();
        send_bits(16'b1, 1);
        i_reset = 1'b1;
        #1;
        check_eq("rst_mid_ready_low", o_ready, 0);
        @(negedge clk);
        check_eq("rst_mid_valid", o_valid, 0);
        check_eq("rst_mid_data", o_data, 0);
        i_reset = 1'b0;
        #1;
        check_eq("rst_mid_ready_high", o_ready, 1);
        clear_q();
        repeat (3) @(negedge clk);
        check_eq("rst_mid_quiet", q.size(), 0);
        send_bits(16'b1000000, 7);
        drain();
        check_eq("rst_impulse_bits", q_bits(), 32'b11_01_11_11_00_10_11);
        check_eq("rst_impulse_count", q.size(), 14);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
